// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH runtime-programmable clock dividers.
// Each channel has a square-wave and a tick output; new divisors apply at the period boundary.
module clock_divider_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 27,
  parameter int DEFAULT_DIV = 100000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DIV0 = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [NUM_CH-1:0] pend_full;
  logic busy;
  logic xfer;
  logic div_bad;

  // slot state of the addressed channel; a nonexistent channel reads busy
  always_comb begin
    busy = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) busy = pend_full[i];
    end
  end

  assign cfg_ready = !busy;
  assign xfer = cfg_valid && cfg_ready;
  assign div_bad = cfg_div < TWO;

  // flag accepted writes whose divisor cannot produce a period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cfg_err <= 1'b0;
    else      cfg_err <= xfer && div_bad;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] lo_len;
    logic full;
    logic clk_q;
    logic tick_q;
    logic wr;
    logic wrap;
    logic hi;

    assign wr = xfer && !div_bad && (cfg_ch == CH_W'(g));
    assign wrap = cnt == div - ONE;
    assign lo_len = div - (div >> 1);
    assign hi = cnt >= lo_len;

    assign pend_full[g] = full;
    assign clk_out[g] = clk_q;
    assign tick[g] = tick_q;

    // period counter, registered phase/tick and pending-divisor slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt    <= '0;
        div    <= DIV0;
        pend   <= '0;
        full   <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (wr) begin
          pend <= cfg_div;
          full <= 1'b1;
        end
        unique case (1'b1)
          !en[g]: begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            if (full) begin
              div  <= pend;
              full <= 1'b0;
            end
          end
          en[g] && wrap: begin
            cnt    <= '0;
            clk_q  <= hi;
            tick_q <= 1'b1;
            if (full) begin
              div  <= pend;
              full <= 1'b0;
            end
          end
          default: begin
            cnt    <= cnt + ONE;
            clk_q  <= hi;
            tick_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
